rr_mux_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares one WIDTH-bit output channel among CHANNELS requesters.
- Picks a winner, drives the select of an internal Mux instance and routes a valid/ready handshake.
- Holds the grant until the winner's last beat transfers, then rotates priority.
- Sits in front of any shared downstream consumer (bus port, FIFO, serializer).

---
 rtl/mux_arb_pkg.sv | 50 +++++
 rtl/rr_mux_arbiter_mux.sv | 21 ++
 rtl/rr_mux_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state type and arbitration helpers for rr_mux_arbiter
package mux_arb_pkg;

   // Upper bound on select width; the pick helper works on vectors of this size
   localparam int MAX_SIZE = 6;
   localparam int MAX_CH   = 1 << MAX_SIZE;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef struct packed {
      logic                found;
      logic [MAX_SIZE-1:0] idx;
   } pick_t;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int unsigned value);
      int          r;
      int unsigned v;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // First set bit of req searched from ptr+1 upward, wrapping modulo n
   function automatic pick_t rr_pick(input logic [MAX_CH-1:0]   req,
                                     input logic [MAX_SIZE-1:0] ptr,
                                     input int unsigned         n);
      pick_t               r;
      logic [MAX_SIZE-1:0] c;
      r = '0;
      for (int unsigned k = 1; k <= MAX_CH; k++) begin
         if (!r.found && k <= n) begin
            c = MAX_SIZE'((ptr + k) % n);
            if (req[c]) begin
               r.found = 1'b1;
               r.idx   = c;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// rtl/rr_mux_arbiter_mux.sv - parameterised N-to-1 data mux, N = 2**SIZE
module rr_mux_arbiter_mux #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 2
) (
   input  logic [(2**SIZE)*WIDTH-1:0] data,
   input  logic [SIZE-1:0]            sel,
   output logic [WIDTH-1:0]           y
);

   // Route the selected channel's slice to the output
   always_comb begin
      y = '0;
      for (int i = 0; i < 2**SIZE; i++) begin
         if (sel == SIZE'(i)) begin
            y = data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin packet-locking arbiter over a shared channel; optional idle timeout under MUXARB_TIMEOUT_EN
module rr_mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 2,
   parameter int CHANNELS = 2**SIZE,
   parameter int TIMEOUT  = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS-1:0]       in_last,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic                      out_last,
   output logic [WIDTH-1:0]          out_data,
   input  logic                      out_ready,
   output logic [SIZE-1:0]           out_sel,
   output logic [CHANNELS-1:0]       grant
`ifdef MUXARB_TIMEOUT_EN
   ,
   output logic                      timeout_err
`endif
);

   if (CHANNELS != 2**SIZE || SIZE > MAX_SIZE || SIZE < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("rr_mux_arbiter: CHANNELS must equal 2**SIZE, SIZE in 1..MAX_SIZE, TIMEOUT >= 1");
   end

   state_t              state, state_n;
   logic [SIZE-1:0]     ptr, ptr_n, sel_n;
   logic [CHANNELS-1:0] grant_n;
   logic [MAX_CH-1:0]   req_ext;
   pick_t               pick;
   logic                xfer;
   logic                tmo_hit;
   logic                release_lock;

   // Round-robin search over the current requests, starting after the last owner
   always_comb begin
      req_ext                 = '0;
      req_ext[CHANNELS-1:0]   = in_valid;
      pick                    = rr_pick(req_ext, MAX_SIZE'(ptr), CHANNELS);
   end

   // Shared channel is only driven while a packet owns it
   assign out_valid    = (state == BUSY) && in_valid[out_sel];
   assign out_last     = (state == BUSY) && in_last[out_sel];
   assign in_ready     = grant & {CHANNELS{out_ready}};
   assign xfer         = out_valid && out_ready;
   assign release_lock = (xfer && out_last) || tmo_hit;

`ifdef MUXARB_TIMEOUT_EN
   localparam int CNT_W = (clog2(TIMEOUT + 1) > 8) ? clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] idle_cnt;

   assign tmo_hit = (state == BUSY) && !in_valid[out_sel] &&
                    (idle_cnt == CNT_W'(TIMEOUT - 1));

   // Count owner-idle cycles inside a locked packet; ready stalls with valid held do not count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo_hit;
         if (state != BUSY || xfer || tmo_hit) begin
            idle_cnt <= '0;
         end else if (!in_valid[out_sel]) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next state: grant the round-robin winner from IDLE, release on last beat or timeout
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = out_sel;
      grant_n = grant;
      case (state)
         IDLE: begin
            if (pick.found) begin
               sel_n                   = SIZE'(pick.idx);
               grant_n                 = '0;
               grant_n[SIZE'(pick.idx)] = 1'b1;
               state_n                 = BUSY;
            end
         end
         BUSY: begin
            if (release_lock) begin
               ptr_n   = out_sel;
               sel_n   = '0;
               grant_n = '0;
               state_n = IDLE;
            end
         end
         default: begin
            sel_n   = '0;
            grant_n = '0;
            state_n = IDLE;
         end
      endcase
   end

   // State, priority pointer, select and grant registers; out_sel parks at 0 when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= SIZE'(CHANNELS - 1);
         out_sel <= '0;
         grant   <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         out_sel <= sel_n;
         grant   <= grant_n;
      end
   end

   rr_mux_arbiter_mux #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
   ) u_mux (
      .data (in_data),
      .sel  (out_sel),
      .y    (out_data)
   );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

   localparam int WIDTH   = 32;
   localparam int SIZE    = 2;
   localparam int CH      = 4;
   localparam int TIMEOUT = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_last;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]       in_ready;
   logic                out_valid;
   logic                out_last;
   logic [WIDTH-1:0]    out_data;
   logic                out_ready;
   logic [SIZE-1:0]     out_sel;
   logic [CH-1:0]       grant;
`ifdef MUXARB_TIMEOUT_EN
   logic                timeout_err;
`endif

   rr_mux_arbiter #(
      .WIDTH    (WIDTH),
      .SIZE     (SIZE),
      .CHANNELS (CH),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .grant     (grant)
`ifdef MUXARB_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   typedef struct {
      int               ch;
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;

   beat_t         src [CH][$];
   beat_t         pend[CH][$];
   exp_t          sb[$];
   logic [CH-1:0] hold;
   int            seq[CH];
   int            n_tests = 0;
   int            n_fail = 0;
   int            beats_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int ch, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {8'(8'hA0 + ch), 8'(seq[ch]), 16'(k)};
         b.last = (k == len - 1);
         src[ch].push_back(b);
         pend[ch].push_back(b);
      end
      seq[ch]++;
   endtask

   task automatic expect_next(input int ch);
      beat_t b;
      exp_t  e;
      b.last = 1'b0;
      while (!b.last && pend[ch].size() > 0) begin
         b      = pend[ch].pop_front();
         e.ch   = ch;
         e.data = b.data;
         e.last = b.last;
         sb.push_back(e);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < CH; i++) begin
         if (src[i].size() > 0) begin
            in_valid[i]                = !hold[i];
            in_data[i*WIDTH +: WIDTH]  = src[i][0].data;
            in_last[i]                 = src[i][0].last;
         end else begin
            in_valid[i]                = 1'b0;
            in_data[i*WIDTH +: WIDTH]  = '0;
            in_last[i]                 = 1'b0;
         end
      end
   endtask

   task automatic step();
      logic [CH-1:0] fire;
      logic [CH-1:0] eg;
      exp_t          e;
      @(negedge clk);
      fire = in_valid & in_ready;
      if (out_valid && out_ready) begin
         beats_seen++;
         if (sb.size() == 0) begin
            check_eq("beat_without_expect", sb.size(), 1);
         end else begin
            e         = sb.pop_front();
            eg        = '0;
            eg[e.ch]  = 1'b1;
            check_eq("beat_grant", grant, eg);
            check_eq("beat_data", out_data, e.data);
            check_eq("beat_last", out_last, e.last);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
         if (fire[i] && src[i].size() > 0) src[i].delete(0);
      end
      drive_inputs();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, sb.size(), 0);
   endtask

   task automatic wait_beat(input string tag);
      int start;
      int n;
      start = beats_seen;
      n     = 0;
      while (beats_seen == start && n < 20) begin
         step();
         n++;
      end
      check_eq(tag, beats_seen - start, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int pulses;
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b1;
      hold      = '0;
      for (int i = 0; i < CH; i++) seq[i] = 0;

      // all channels request while held in reset
      for (int i = 0; i < CH; i++) add_pkt(i, 1);
      add_pkt(0, 1);
      add_pkt(1, 1);
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_grant", grant, 4'b0000);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 4'b0000);
      check_eq("rst_out_sel", out_sel, 2'd0);
      check_eq("idle_out_data_ch0", out_data, {8'hA0, 8'h00, 16'h0000});
      rst_n = 1'b1;
      expect_next(0);
      expect_next(1);
      expect_next(2);
      expect_next(3);
      expect_next(0);
      expect_next(1);
      step();
      check_eq("first_grant", grant, 4'b0001);
      check_eq("first_out_sel", out_sel, 2'd0);
      drain("t1_rr_order", 40);

      // channel 2 three-beat packet locks out 0 and 3
      add_pkt(2, 3);
      add_pkt(0, 1);
      add_pkt(3, 1);
      drive_inputs();
      expect_next(2);
      expect_next(3);
      expect_next(0);
      drain("t2_lock_order", 40);

      // downstream stall mid-packet
      add_pkt(2, 3);
      drive_inputs();
      expect_next(2);
      start = beats_seen;
      wait_beat("t3_first_beat");
      out_ready = 1'b0;
      repeat (5) begin
         step();
         check_eq("stall_in_ready", in_ready, 4'b0000);
         check_eq("stall_grant", grant, 4'b0100);
         if (sb.size() > 0) check_eq("stall_data", out_data, sb[0].data);
      end
      out_ready = 1'b1;
      drain("t3_stall_drain", 20);
      check_eq("stall_beats", beats_seen - start, 3);

      // owner drops valid while channel 1 requests
      add_pkt(3, 3);
      add_pkt(1, 1);
      drive_inputs();
      expect_next(3);
      expect_next(1);
      wait_beat("t4_first_beat");
      hold[3] = 1'b1;
      drive_inputs();
      repeat (2) begin
         step();
         check_eq("gap_grant", grant, 4'b1000);
         check_eq("gap_out_valid", out_valid, 1'b0);
      end
      hold[3] = 1'b0;
      drive_inputs();
      drain("t4_gap_drain", 20);

      // asynchronous reset mid-packet
      add_pkt(2, 4);
      add_pkt(0, 1);
      add_pkt(3, 1);
      drive_inputs();
      expect_next(2);
      wait_beat("t5_first_beat");
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("areset_grant", grant, 4'b0000);
      check_eq("areset_out_valid", out_valid, 1'b0);
      check_eq("areset_in_ready", in_ready, 4'b0000);
      sb.delete();
      src[2].delete();
      pend[2].delete();
      drive_inputs();
      expect_next(0);
      expect_next(3);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drain("t5_after_reset", 20);

`ifdef MUXARB_TIMEOUT_EN
      // owner goes silent long enough to trip the timeout
      add_pkt(1, 2);
      add_pkt(2, 1);
      drive_inputs();
      expect_next(1);
      wait_beat("t6_first_beat");
      hold[1] = 1'b1;
      drive_inputs();
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (timeout_err) begin
            pulses++;
            if (pulses == 1) begin
               check_eq("tmo_grant", grant, 4'b0000);
               check_eq("tmo_wait", k, 3);
               sb.delete();
               src[1].delete();
               pend[1].delete();
               hold[1] = 1'b0;
               drive_inputs();
               expect_next(2);
            end
         end
      end
      check_eq("tmo_pulses", pulses, 1);
      drain("t6_after_timeout", 10);
`endif

      repeat (3) step();
      check_eq("final_idle_grant", grant, 4'b0000);
      check_eq("final_idle_valid", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
